// File: rtl/iiitb_spi_pkg.sv
// Shared types and constants for the iiitb SPI flash read controller.
package iiitb_spi_pkg;

  localparam logic [7:0]  SPI_CMD_READ = 8'h03;
  localparam int unsigned SPI_ADDR_W   = 24;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    DATA,
    STOP,
    GAP
  } spi_rd_state_t;

endpackage

// File: rtl/iiitb_spi_sck_gen.sv
// SPI clock divider: CLK_DIV cycles per flash_clk phase, with edge strobes
// and a hold input that can stretch the low phase.
module iiitb_spi_sck_gen #(
  parameter int unsigned CLK_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic sck_en_i,
  input  logic hold_i,
  output logic sck_o,
  output logic rise_o,
  output logic fall_o,
  output logic tick_o
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [7:0] div_q, div_d;
  logic       sck_q, sck_d;
  logic       frozen;

  // Strobes are asserted in the cycle whose closing edge toggles flash_clk.
  always_comb begin
    frozen = hold_i && !sck_q;
    tick_o = run_i && !frozen && (div_q == DIV_LAST);
    rise_o = tick_o && sck_en_i && !sck_q;
    fall_o = tick_o && sck_q;
    div_d  = div_q;
    sck_d  = sck_q;
    if (!run_i) begin
      div_d = '0;
      sck_d = 1'b0;
    end else if (!frozen) begin
      div_d = tick_o ? '0 : div_q + 8'd1;
      if (rise_o || fall_o) sck_d = !sck_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      div_q <= '0;
      sck_q <= 1'b0;
    end else begin
      div_q <= div_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o = sck_q;

endmodule

// File: rtl/iiitb_spiflash_reader.sv
// SPI flash READ (0x03) initiator: opcode + 24-bit address out, len bytes in,
// returned on a ready/valid byte stream that can stall flash_clk.
module iiitb_spiflash_reader
  import iiitb_spi_pkg::*;
#(
  parameter int unsigned CLK_DIV = 2,
  parameter int unsigned LEN_W   = 16
) (
  input  logic                  clock,
  input  logic                  resetb,
  input  logic                  start,
  input  logic [SPI_ADDR_W-1:0] addr,
  input  logic [LEN_W-1:0]      len,
  output logic                  busy,
  output logic                  done,
  output logic [7:0]            data_o,
  output logic                  data_valid,
  input  logic                  data_ready,
  output logic                  flash_csb,
  output logic                  flash_clk,
  output logic                  flash_io0,
  input  logic                  flash_io1
);

  spi_rd_state_t    state_q, state_d;
  logic [31:0]      tx_q, tx_d;
  logic [7:0]       rx_q, rx_d;
  logic [7:0]       data_q, data_d;
  logic [4:0]       bit_q, bit_d;
  logic [LEN_W-1:0] byte_q, byte_d;
  logic             rx_full_q, rx_full_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             csb_q, csb_d;

  logic accept, more_bytes;
  logic sck_run, sck_en, sck_hold;
  logic sck, sck_rise, sck_fall, sck_tick;

  assign accept     = (state_q == IDLE) && start && !busy_q;
  assign more_bytes = (byte_q != '0);
  assign sck_run    = state_q inside {CMD, ADDR, DATA, GAP};
  assign sck_en     = (state_q inside {CMD, ADDR}) || ((state_q == DATA) && more_bytes);
  // Stretch the first-bit low phase while the previous byte is unconsumed.
  assign sck_hold   = (state_q == DATA) && more_bytes && (bit_q == '0) &&
                      valid_q && !data_ready;

  iiitb_spi_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .clk_i    (clock),
    .rst_ni   (resetb),
    .run_i    (sck_run),
    .sck_en_i (sck_en),
    .hold_i   (sck_hold),
    .sck_o    (sck),
    .rise_o   (sck_rise),
    .fall_o   (sck_fall),
    .tick_o   (sck_tick)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    rx_d      = rx_q;
    bit_d     = bit_q;
    byte_d    = byte_q;
    rx_full_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          tx_d   = {SPI_CMD_READ, addr};
          byte_d = len;
          bit_d  = '0;
          if (len != '0) state_d = CMD;
        end
      end
      CMD, ADDR: begin
        if (sck_fall) begin
          tx_d = {tx_q[30:0], 1'b0};
          if ((state_q == CMD) && (bit_q == 5'd7)) begin
            bit_d   = '0;
            state_d = ADDR;
          end else if ((state_q == ADDR) && (bit_q == 5'd23)) begin
            bit_d   = '0;
            state_d = DATA;
          end else begin
            bit_d = bit_q + 5'd1;
          end
        end
      end
      DATA: begin
        if (!more_bytes) begin
          // Last bit done: wait out the CS hold time before raising CS.
          if (sck_tick) state_d = STOP;
        end else begin
          if (sck_rise) begin
            rx_d      = {rx_q[6:0], flash_io1};
            rx_full_d = (bit_q == 5'd7);
          end
          if (sck_fall) begin
            if (bit_q == 5'd7) begin
              bit_d  = '0;
              byte_d = byte_q - LEN_W'(1);
            end else begin
              bit_d = bit_q + 5'd1;
            end
          end
        end
      end
      STOP:    state_d = GAP;
      GAP:     if (sck_tick) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    if (valid_q && data_ready) valid_d = 1'b0;
    if (rx_full_q) begin
      data_d  = rx_q;
      valid_d = 1'b1;
    end
    csb_d  = !(state_d inside {CMD, ADDR, DATA});
    busy_d = (state_d != IDLE) || accept;
    done_d = (state_d == STOP) || (accept && (len == '0));
  end

  always_ff @(posedge clock or negedge resetb) begin
    if (!resetb) begin
      state_q   <= IDLE;
      tx_q      <= '0;
      rx_q      <= '0;
      data_q    <= '0;
      bit_q     <= '0;
      byte_q    <= '0;
      rx_full_q <= 1'b0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      csb_q     <= 1'b1;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      rx_q      <= rx_d;
      data_q    <= data_d;
      bit_q     <= bit_d;
      byte_q    <= byte_d;
      rx_full_q <= rx_full_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      csb_q     <= csb_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign data_o     = data_q;
  assign data_valid = valid_q;
  assign flash_csb  = csb_q;
  assign flash_clk  = sck;
  assign flash_io0  = (state_q inside {CMD, ADDR}) ? tx_q[31] : 1'b0;

endmodule
